// File: rtl/impl_mon_pkg.sv
// impl_mon_pkg: shared types and limits for the implication monitor
package impl_mon_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, FAILED = 2'd2} mon_state_t;
  localparam int MAX_DELAY = 16;
endpackage

// File: rtl/impl_mon_sat_cnt.sv
// impl_mon_sat_cnt: saturating up-counter with sync reset and clear
module impl_mon_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk)
    if (rst || clr) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/impl_mon.sv
// impl_mon: hardware checker for a |-> ##DELAY b; IMPL_MON_TIMESTAMP_EN adds first-fail capture
module impl_mon
  import impl_mon_pkg::*;
#(
  parameter int DELAY = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             clear,
  output logic             pass_pulse,
  output logic             fail_pulse,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output mon_state_t       state
`ifdef IMPL_MON_TIMESTAMP_EN
  ,
  output logic [CNT_W-1:0] first_fail_cyc,
  output logic             first_fail_vld
`endif
);
  if (DELAY < 1 || DELAY > MAX_DELAY) begin : g_bad_delay
    $error("impl_mon: DELAY must be within 1..MAX_DELAY");
  end
  logic [DELAY-1:0] pend_q, pend_d;
  logic             pass_q, pass_d, fail_q, fail_d;
  mon_state_t       state_q, state_d;
  // the oldest pending slot is the attempt whose consequent is sampled this edge
  always_comb begin
    pend_d  = (pend_q << 1) | DELAY'(en & a);
    pass_d  = pend_q[DELAY-1] & b;
    fail_d  = pend_q[DELAY-1] & ~b;
    state_d = (fail_d || state_q == FAILED) ? FAILED : (|pend_d) ? ACTIVE : IDLE;
  end
  always_ff @(posedge clk)
    if (rst || clear) begin
      pend_q  <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      state_q <= IDLE;
    end else begin
      pend_q  <= pend_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      state_q <= state_d;
    end
  impl_mon_sat_cnt #(.W(CNT_W)) u_pass_cnt (
    .clk(clk), .rst(rst), .clr(clear), .inc(pass_d), .cnt(pass_cnt)
  );
  impl_mon_sat_cnt #(.W(CNT_W)) u_fail_cnt (
    .clk(clk), .rst(rst), .clr(clear), .inc(fail_d), .cnt(fail_cnt)
  );
  assign pass_pulse = pass_q;
  assign fail_pulse = fail_q;
  assign state      = state_q;
`ifdef IMPL_MON_TIMESTAMP_EN
  logic [CNT_W-1:0] cycle_q, cycle_d, ffc_q, ffc_d;
  logic             ffv_q, ffv_d;
  always_comb begin
    cycle_d = cycle_q + 1'b1;
    ffc_d   = (fail_d && !ffv_q) ? cycle_q : ffc_q;
    ffv_d   = ffv_q | fail_d;
  end
  always_ff @(posedge clk)
    if (rst || clear) begin
      cycle_q <= '0;
      ffc_q   <= '0;
      ffv_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      ffc_q   <= ffc_d;
      ffv_q   <= ffv_d;
    end
  assign first_fail_cyc = ffc_q;
  assign first_fail_vld = ffv_q;
`endif
endmodule

// File: tb/tb_impl_mon.sv
// tb_impl_mon: directed self-checking bench for impl_mon
module tb_impl_mon;
  import impl_mon_pkg::*;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, a = 1'b0, b = 1'b0, clear = 1'b0;
  int checks = 0, failures = 0;
  logic d1_pp, d1_fp, d3_pp, d3_fp, c2_pp, c2_fp;
  logic [15:0] d1_pc, d1_fc, d3_pc, d3_fc;
  logic [1:0] c2_pc, c2_fc;
  mon_state_t d1_st, d3_st, c2_st;
`ifdef IMPL_MON_TIMESTAMP_EN
  logic [15:0] d1_ffc, d3_ffc;
  logic [1:0] c2_ffc;
  logic d1_ffv, d3_ffv, c2_ffv;
`endif
  always #5 clk = ~clk;
  impl_mon #(.DELAY(1), .CNT_W(16)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .clear(clear),
    .pass_pulse(d1_pp), .fail_pulse(d1_fp), .pass_cnt(d1_pc), .fail_cnt(d1_fc), .state(d1_st)
`ifdef IMPL_MON_TIMESTAMP_EN
    , .first_fail_cyc(d1_ffc), .first_fail_vld(d1_ffv)
`endif
  );
  impl_mon #(.DELAY(3), .CNT_W(16)) u_d3 (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .clear(clear),
    .pass_pulse(d3_pp), .fail_pulse(d3_fp), .pass_cnt(d3_pc), .fail_cnt(d3_fc), .state(d3_st)
`ifdef IMPL_MON_TIMESTAMP_EN
    , .first_fail_cyc(d3_ffc), .first_fail_vld(d3_ffv)
`endif
  );
  impl_mon #(.DELAY(1), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .clear(clear),
    .pass_pulse(c2_pp), .fail_pulse(c2_fp), .pass_cnt(c2_pc), .fail_cnt(c2_fc), .state(c2_st)
`ifdef IMPL_MON_TIMESTAMP_EN
    , .first_fail_cyc(c2_ffc), .first_fail_vld(c2_ffv)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_clear();
    a = 1'b0; b = 1'b0; en = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask
  initial begin
    tick(2);
    check("rst_pp", 32'(d1_pp), 0);
    check("rst_fp", 32'(d1_fp), 0);
    check("rst_pc", 32'(d1_pc), 0);
    check("rst_fc", 32'(d1_fc), 0);
    check("rst_st", 32'(d1_st), 32'(IDLE));
    check("rst_c2_st", 32'(c2_st), 32'(IDLE));
    rst = 1'b0;
    // simple pass, DELAY=1
    a = 1; b = 0; tick();
    check("p1_st_active", 32'(d1_st), 32'(ACTIVE));
    check("p1_no_pulse", 32'({d1_pp, d1_fp}), 0);
    a = 0; b = 1; tick();
    check("p1_pp", 32'(d1_pp), 1);
    check("p1_fp", 32'(d1_fp), 0);
    check("p1_pc", 32'(d1_pc), 1);
    check("p1_fc", 32'(d1_fc), 0);
    check("p1_st_idle", 32'(d1_st), 32'(IDLE));
    b = 0; tick();
    check("p1_pp_drop", 32'(d1_pp), 0);
    // simple fail, sticky until clear
    do_clear();
    a = 1; b = 0; tick();
    a = 0; tick();
    check("f1_fp", 32'(d1_fp), 1);
    check("f1_pp", 32'(d1_pp), 0);
    check("f1_fc", 32'(d1_fc), 1);
    check("f1_st", 32'(d1_st), 32'(FAILED));
    tick(3);
    check("f1_fp_drop", 32'(d1_fp), 0);
    check("f1_sticky", 32'(d1_st), 32'(FAILED));
    do_clear();
    check("f1_clr_st", 32'(d1_st), 32'(IDLE));
    check("f1_clr_fc", 32'(d1_fc), 0);
    // en=0 blocks new attempts
    en = 0; a = 1; tick();
    en = 1; a = 0; tick();
    check("en0_fp", 32'(d1_fp), 0);
    check("en0_st", 32'(d1_st), 32'(IDLE));
    // en dropped with attempt in flight still reports
    a = 1; b = 0; tick();
    en = 0; b = 1; tick();
    check("enfl_pp", 32'(d1_pp), 1);
    b = 0; tick();
    check("enfl_blocked", 32'({d1_pp, d1_fp}), 0);
    en = 1; a = 0;
    // overlapping attempts: 4 consecutive fails
    do_clear();
    a = 1; b = 0; tick();
    check("ov_e1", 32'(d1_fp), 0);
    tick();
    check("ov_e2", 32'(d1_fp), 1);
    tick();
    check("ov_e3", 32'(d1_fp), 1);
    tick();
    check("ov_e4", 32'(d1_fp), 1);
    a = 0; tick();
    check("ov_e5", 32'(d1_fp), 1);
    check("ov_fc", 32'(d1_fc), 4);
    tick();
    check("ov_end", 32'(d1_fp), 0);
    // clear beats a maturing attempt
    do_clear();
    a = 1; b = 0; tick();
    a = 0; clear = 1; tick();
    clear = 0;
    check("clrm_fp", 32'(d1_fp), 0);
    check("clrm_fc", 32'(d1_fc), 0);
    check("clrm_st", 32'(d1_st), 32'(IDLE));
    tick();
    check("clrm_fp2", 32'(d1_fp), 0);
    // DELAY=3 pass then fail
    do_clear();
    a = 1; b = 0; tick();
    check("d3_st_act", 32'(d3_st), 32'(ACTIVE));
    a = 0; tick(2);
    check("d3_early", 32'({d3_pp, d3_fp}), 0);
    b = 1; tick();
    check("d3_pp", 32'(d3_pp), 1);
    check("d3_pc", 32'(d3_pc), 1);
    check("d3_st_idle", 32'(d3_st), 32'(IDLE));
    b = 0; tick();
    check("d3_pp_drop", 32'(d3_pp), 0);
    a = 1; tick();
    a = 0; tick();
    b = 1; tick();
    b = 0; tick();
    check("d3_fp", 32'(d3_fp), 1);
    check("d3_fc", 32'(d3_fc), 1);
    check("d3_st_fail", 32'(d3_st), 32'(FAILED));
    // CNT_W=2 saturation, then clear drops pending attempt
    do_clear();
    a = 1; b = 1; tick(5);
    a = 0; tick();
    check("sat_pp", 32'(c2_pp), 1);
    check("sat_pc", 32'(c2_pc), 3);
    a = 1; tick();
    a = 0; clear = 1; tick();
    clear = 0;
    check("sat_clr_pc", 32'(c2_pc), 0);
    check("sat_clr_st", 32'(c2_st), 32'(IDLE));
    check("sat_clr_pp", 32'(c2_pp), 0);
    tick();
    check("sat_drop_pp", 32'(c2_pp), 0);
    check("sat_drop_pc", 32'(c2_pc), 0);
`ifdef IMPL_MON_TIMESTAMP_EN
    b = 0; do_clear();
    check("ts_vld0", 32'(d1_ffv), 0);
    tick(11);
    a = 1; tick();
    a = 0; tick();
    check("ts_vld", 32'(d1_ffv), 1);
    check("ts_cyc", 32'(d1_ffc), 12);
    tick(6);
    a = 1; tick();
    a = 0; tick();
    check("ts_fc2", 32'(d1_fc), 2);
    check("ts_cyc_keep", 32'(d1_ffc), 12);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
